sar_compare_search: RTL
=======================

// Module: sar_compare_search
// PURPOSE
//  Binary-search controller that drives the B operand of the 4-bit magnitude comparator and consumes its 3-bit active-low result code.
//  Recovers an unknown operand A held on the comparator's other input. Reports A's value, or reports that it was not found.
//  Sits between the comparator and any front end that needs A digitised through compare-only access.
// PARAMETERS
//  WIDTH          4  operand width; search range 0 .. 2^WIDTH-1
//  SETTLE_CYCLES  1  wait cycles after each new guess before cmp_code is sampled; 0 = sample on the next cycle
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      synchronous reset, active low
//  start     in   1      request a search; accepted only in IDLE
//  cmp_code  in   3      comparator result, one-cold: 3'b011 A>B (GT), 3'b110 A<B (LT), 3'b101 A==B (EQ)
//  guess     out  WIDTH  drives comparator B; registered
//  busy      out  1      high from the start-accept edge until DONE is entered
//  done      out  1      one-cycle pulse when the search ends
//  found     out  1      1 = result valid and equal to A; held until next accepted start
//  result    out  WIDTH  final guess; held until next accepted start
//  err       out  1      1 = invalid cmp_code seen; held until next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; guess, result=0; busy, done, found, err=0; lo=0, hi=2^WIDTH-1; settle counter=0.
//  - Reset mid-search: aborts immediately to the reset values above. No done pulse is issued.
//  - States are IDLE, DRIVE, SAMPLE and DONE.
//  - IDLE: on start=1, clear found/err/result, set lo=0, hi=max, guess=(lo+hi)>>1 (=7 for WIDTH 4), busy=1.
//    Go to DRIVE, or to SAMPLE if SETTLE_CYCLES=0.
//  - DRIVE: count SETTLE_CYCLES cycles, then go to SAMPLE.
//  - SAMPLE: evaluate cmp_code in this single cycle.
//    - EQ: found=1, result=guess -> DONE.
//    - GT: if guess==max -> found=0, result=guess -> DONE; else lo=guess+1 and compute the next guess.
//    - LT: if guess==0 -> found=0, result=guess -> DONE; else hi=guess-1 and compute the next guess.
//    - Next guess: guess=lo'+((hi'-lo')>>1), using the updated lo/hi; go to DRIVE (or stay in SAMPLE if SETTLE_CYCLES=0).
//    - If lo'>hi' after the update -> found=0, result=guess -> DONE.
//    - Any other code (000, 001, 010, 100, 111): err=1, found=0, result=guess -> DONE.
//  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
//  - start while busy or in DONE is ignored; it is not queued.
//  - Arithmetic: lo/hi/guess are WIDTH+1 bits internally so guess+1 and guess-1 never wrap. Outputs are the low WIDTH bits.
//  - Compare count is at most WIDTH+1.
//  - done rises n*(SETTLE_CYCLES+1) clocks after the start-accept edge, where n = number of compares.
//  - guess is stable for the full DRIVE+SAMPLE window of each compare.
// CONFIGURATION
//  - Macro SAR_STEP_COUNT_EN.
//  - Defined: adds output steps [$clog2(WIDTH+2)-1:0].
//    Cleared on start accept, incremented on each SAMPLE, held after DONE, reset to 0.
//  - Undefined: no steps port and no step counter logic.
// TESTING  (WIDTH=4, SETTLE_CYCLES=1, bench models an ideal comparator)
//  1. A=9, start pulse -> guesses 7,11,9; codes GT,LT,EQ. done 6 clks after accept; found=1, result=9, err=0; steps=3 if enabled.
//  2. A=0 -> guesses 7,3,1,0; done; found=1, result=0; steps=4.
//  3. A=15 -> guesses 7,11,13,14,15; found=1, result=15; steps=5 (WIDTH+1); done 10 clks after accept.
//  4. cmp_code forced 3'b111 -> after first SAMPLE: err=1, found=0, result=7; done pulse width exactly 1.
//  5. cmp_code forced GT (3'b011) always -> guesses 7,11,13,14,15; found=0, result=15, err=0.
//  6. Start A=9, assert rst_n=0 at the 2nd guess -> next cycle all outputs 0, IDLE, no done. Re-start -> result=9.
//     Also: start held high while busy -> exactly one search is performed.

Source files
------------

// File: rtl/sar_compare_search.sv
// Binary-search controller recovering comparator operand A by driving operand B.
// Optional step counter output enabled by defining SAR_STEP_COUNT_EN.
module sar_compare_search #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       cmp_code,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
`ifdef SAR_STEP_COUNT_EN
    output logic             err,
    output logic [$clog2(WIDTH+2)-1:0] steps
`else
    output logic             err
`endif
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [W1-1:0] MAXV = {1'b0, {WIDTH{1'b1}}};
    localparam logic [W1-1:0] ZERO = '0;
    localparam logic [CW-1:0] CLAST =
        CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FIN
    } state_t;

    localparam state_t NEXT_WAIT = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

    state_t        state_q, state_d;
    logic [W1-1:0] lo_q, lo_d, hi_q, hi_d, g_q, g_d;
    logic [W1-1:0] nlo, nhi;
    logic [WIDTH-1:0] res_q, res_d;
    logic          found_q, found_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_eq, is_gt, is_lt, step;

    assign is_eq = (cmp_code == 3'b101);
    assign is_gt = (cmp_code == 3'b011);
    assign is_lt = (cmp_code == 3'b110);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= MAXV;
            g_q     <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            g_q     <= g_d;
            res_q   <= res_d;
            found_q <= found_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        g_d     = g_q;
        res_d   = res_q;
        found_d = found_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        nlo     = lo_q;
        nhi     = hi_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    res_d   = '0;
                    lo_d    = '0;
                    hi_d    = MAXV;
                    g_d     = MAXV >> 1;
                    cnt_d   = '0;
                    state_d = NEXT_WAIT;
                end
            end
            DRIVE: begin
                if (cnt_q == CLAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                res_d   = g_q[WIDTH-1:0];
                found_d = 1'b0;
                state_d = FIN;
                unique case (1'b1)
                    is_eq: found_d = 1'b1;
                    is_gt: begin
                        if (g_q != MAXV) begin
                            nlo  = g_q + 1'b1;
                            step = 1'b1;
                        end
                    end
                    is_lt: begin
                        if (g_q != ZERO) begin
                            nhi  = g_q - 1'b1;
                            step = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
                // An empty interval after narrowing means A is not in range.
                if (step) begin
                    lo_d = nlo;
                    hi_d = nhi;
                    if (nlo <= nhi) begin
                        g_d     = nlo + ((nhi - nlo) >> 1);
                        res_d   = res_q;
                        cnt_d   = '0;
                        state_d = NEXT_WAIT;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign guess  = g_q[WIDTH-1:0];
    assign busy   = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done   = (state_q == FIN);
    assign found  = found_q;
    assign result = res_q;
    assign err    = err_q;

`ifdef SAR_STEP_COUNT_EN
    logic [$clog2(WIDTH+2)-1:0] steps_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steps_q <= '0;
        end else if (state_q == IDLE && start) begin
            steps_q <= '0;
        end else if (state_q == SAMPLE) begin
            steps_q <= steps_q + 1'b1;
        end
    end

    assign steps = steps_q;
`endif

endmodule
